// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - fixed-latency, in-order data SRAM responder
//
// Purpose: word-addressed 32-bit SRAM behind a req/addr_ok, data_ok handshake.
// Each accepted request enters a small FIFO and is answered LATENCY cycles
// after acceptance, strictly in acceptance order.
//
// Ports:
//   clk               clock, all state on the rising edge
//   reset             asynchronous active-high reset
//   data_sram_req     request valid
//   data_sram_wr      1 = write, 0 = read
//   data_sram_wstrb   byte-lane write enables (writes only)
//   data_sram_addr    byte address; word index is addr[ADDR_W+1:2]
//   data_sram_wdata   write data
//   data_sram_addr_ok request accepted when high together with req (= not full)
//   data_sram_data_ok one-cycle response pulse
//   data_sram_rdata   read data for read responses, zero otherwise

module data_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = 4;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(LATENCY);

  logic [31:0]      mem    [0:(1<<ADDR_W)-1];
  logic [31:0]      q_data [0:QDEPTH-1];
  logic [AGE_W-1:0] q_age  [0:QDEPTH-1];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [ADDR_W-1:0] idx;
  logic              full;
  logic              empty;
  logic              accept;
  logic              retire;
  logic              unused_addr;

  // Upper address bits alias onto the same word; byte offset is irrelevant.
  assign idx         = data_sram_addr[ADDR_W+1:2];
  assign unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  assign full   = (count == CNT_W'(QDEPTH));
  assign empty  = (count == '0);
  assign accept = data_sram_req & ~full;
  // The head entry is answered once it has aged LATENCY cycles; a new entry
  // starts at age 1 so it is due in the cycle after edge T+LATENCY-1.
  assign retire = ~empty & (q_age[rd_ptr] == AGE_MAX);

  // No bypass: a retiring head does not free a slot until the next edge.
  assign data_sram_addr_ok = ~full;
  assign data_sram_data_ok = retire;
  assign data_sram_rdata   = retire ? q_data[rd_ptr] : 32'h0;

  // Memory is deliberately not reset so accepted writes survive a reset.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) begin
          mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_age[i]  <= '0;
        q_data[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (q_age[i] != AGE_MAX) begin
          q_age[i] <= q_age[i] + AGE_W'(1);
        end
      end
      if (accept) begin
        // Reads capture the word before this edge's write; only one request
        // is accepted per cycle so no same-cycle write can be missed.
        q_age[wr_ptr]  <= AGE_W'(1);
        q_data[wr_ptr] <= data_sram_wr ? 32'h0 : mem[idx];
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (retire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({accept, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - directed self-checking bench for data_sram_responder

module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req = 1'b0, wr = 1'b0;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  logic        req8 = 1'b0, wr8 = 1'b0;
  logic [3:0]  wstrb8 = 4'h0;
  logic [31:0] addr8 = 32'h0, wdata8 = 32'h0;
  logic        addr_ok8, data_ok8;
  logic [31:0] rdata8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(10), .LATENCY(2), .QDEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .data_sram_req(req), .data_sram_wr(wr), .data_sram_wstrb(wstrb),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok),
    .data_sram_rdata(rdata)
  );

  data_sram_responder #(.ADDR_W(10), .LATENCY(8), .QDEPTH(4)) dut8 (
    .clk(clk), .reset(reset),
    .data_sram_req(req8), .data_sram_wr(wr8), .data_sram_wstrb(wstrb8),
    .data_sram_addr(addr8), .data_sram_wdata(wdata8),
    .data_sram_addr_ok(addr_ok8), .data_sram_data_ok(data_ok8),
    .data_sram_rdata(rdata8)
  );

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic issue(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; wr = w; wstrb = s; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; wr = 1'b0;
  endtask

  task automatic issue8(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    req8 = 1'b1; wr8 = w; wstrb8 = s; addr8 = a; wdata8 = d;
    @(posedge clk);
    @(negedge clk);
    req8 = 1'b0; wr8 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (data_ok !== 1'b0) begin failures++; $display("FAIL rst_data_ok actual=%b expected=0", data_ok); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata actual=%h expected=00000000", rdata); end
    checks++; if (data_ok8 !== 1'b0) begin failures++; $display("FAIL rst_data_ok8 actual=%b expected=0", data_ok8); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (addr_ok !== 1'b1) begin failures++; $display("FAIL rst_addr_ok actual=%b expected=1", addr_ok); end
  endtask

  task automatic test_write_read();
    issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    checks++; if (data_ok !== 1'b0) begin failures++; $display("FAIL wr_early actual=%b expected=0", data_ok); end
    @(negedge clk);
    checks++; if (data_ok !== 1'b1 || rdata !== 32'h0) begin failures++; $display("FAIL wr_resp actual=%b/%h expected=1/00000000", data_ok, rdata); end
    @(negedge clk);
    checks++; if (data_ok !== 1'b0) begin failures++; $display("FAIL wr_pulse_width actual=%b expected=0", data_ok); end
    issue(1'b0, 4'h0, 32'h10, 32'h0);
    checks++; if (data_ok !== 1'b0) begin failures++; $display("FAIL rd_early actual=%b expected=0", data_ok); end
    @(negedge clk);
    checks++; if (data_ok !== 1'b1 || rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_resp actual=%b/%h expected=1/deadbeef", data_ok, rdata); end
    @(negedge clk);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rd_idle_rdata actual=%h expected=00000000", rdata); end
  endtask

  task automatic test_partial();
    issue(1'b1, 4'b0010, 32'h10, 32'h0000AA00);
    repeat (2) @(negedge clk);
    issue(1'b0, 4'hF, 32'h10, 32'hFFFFFFFF);
    @(negedge clk);
    checks++; if (data_ok !== 1'b1 || rdata !== 32'hDEADAAEF) begin failures++; $display("FAIL partial_rd actual=%b/%h expected=1/deadaaef", data_ok, rdata); end
    @(negedge clk);
    issue(1'b0, 4'h0, 32'h13, 32'h0);
    @(negedge clk);
    checks++; if (data_ok !== 1'b1 || rdata !== 32'hDEADAAEF) begin failures++; $display("FAIL offset_rd actual=%b/%h expected=1/deadaaef", data_ok, rdata); end
    @(negedge clk);
    issue(1'b0, 4'h0, 32'h0000_1010, 32'h0);
    @(negedge clk);
    checks++; if (data_ok !== 1'b1 || rdata !== 32'hDEADAAEF) begin failures++; $display("FAIL alias_rd actual=%b/%h expected=1/deadaaef", data_ok, rdata); end
    @(negedge clk);
  endtask

  task automatic test_strb_zero();
    issue(1'b1, 4'hF, 32'h30, 32'h12345678);
    repeat (2) @(negedge clk);
    issue(1'b1, 4'h0, 32'h30, 32'hFFFFFFFF);
    @(negedge clk);
    checks++; if (data_ok !== 1'b1 || rdata !== 32'h0) begin failures++; $display("FAIL strb0_resp actual=%b/%h expected=1/00000000", data_ok, rdata); end
    @(negedge clk);
    issue(1'b0, 4'h0, 32'h30, 32'h0);
    @(negedge clk);
    checks++; if (data_ok !== 1'b1 || rdata !== 32'h12345678) begin failures++; $display("FAIL strb0_rd actual=%b/%h expected=1/12345678", data_ok, rdata); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    req = 1'b1; wr = 1'b1; wstrb = 4'hF; addr = 32'h20; wdata = 32'h11111111;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; wdata = 32'h0;
    checks++; if (data_ok !== 1'b0) begin failures++; $display("FAIL b2b_early actual=%b expected=0", data_ok); end
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    checks++; if (data_ok !== 1'b1 || rdata !== 32'h0) begin failures++; $display("FAIL b2b_wr_resp actual=%b/%h expected=1/00000000", data_ok, rdata); end
    @(negedge clk);
    checks++; if (data_ok !== 1'b1 || rdata !== 32'h11111111) begin failures++; $display("FAIL b2b_rd_resp actual=%b/%h expected=1/11111111", data_ok, rdata); end
    @(negedge clk);
    checks++; if (data_ok !== 1'b0) begin failures++; $display("FAIL b2b_tail actual=%b expected=0", data_ok); end
  endtask

  task automatic test_full_queue();
    int acc, resp, first_low, first_ok, back_hi;
    logic ok_s, dok_s, req_s;
    logic [31:0] rd_s;
    logic [31:0] expw [0:3];
    for (int k = 0; k < 4; k++) begin
      expw[k] = 32'hA0A00000 + 32'(k);
      issue8(1'b1, 4'hF, 32'h200 + 32'(4*k), expw[k]);
    end
    repeat (12) @(negedge clk);
    acc = 0; resp = 0; first_low = -1; first_ok = -1; back_hi = -1;
    for (int n = 0; n < 60 && (acc < 6 || resp < 6); n++) begin
      req8 = (acc < 6); wr8 = 1'b0; addr8 = 32'h200 + 32'(4*(acc%4));
      req_s = req8; ok_s = addr_ok8; dok_s = data_ok8; rd_s = rdata8;
      if (!ok_s && first_low < 0) first_low = n;
      if (ok_s && first_low >= 0 && back_hi < 0) back_hi = n;
      if (dok_s) begin
        if (first_ok < 0) first_ok = n;
        checks++; if (rd_s !== expw[resp%4]) begin failures++; $display("FAIL fullq_order resp=%0d actual=%h expected=%h", resp, rd_s, expw[resp%4]); end
        resp++;
      end
      @(posedge clk);
      if (ok_s && req_s) acc++;
      @(negedge clk);
    end
    req8 = 1'b0;
    checks++; if (acc != 6 || resp != 6) begin failures++; $display("FAIL fullq_counts actual=%0d/%0d expected=6/6", acc, resp); end
    checks++; if (first_low != 4) begin failures++; $display("FAIL fullq_addr_ok_fall actual=%0d expected=4", first_low); end
    checks++; if (first_ok != 8) begin failures++; $display("FAIL fullq_first_data_ok actual=%0d expected=8", first_ok); end
    checks++; if (back_hi != 9) begin failures++; $display("FAIL fullq_addr_ok_return actual=%0d expected=9", back_hi); end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    int pulses;
    bit got;
    issue8(1'b1, 4'hF, 32'h40, 32'hCAFEF00D);
    repeat (10) @(negedge clk);
    pulses = 0;
    req8 = 1'b1; wr8 = 1'b0; addr8 = 32'h40;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (data_ok8) pulses++;
    end
    req8 = 1'b0;
    @(negedge clk);
    if (data_ok8) pulses++;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (data_ok8) pulses++;
    end
    reset = 1'b0;
    checks++; if (addr_ok8 !== 1'b1) begin failures++; $display("FAIL midrst_addr_ok actual=%b expected=1", addr_ok8); end
    repeat (12) begin
      @(negedge clk);
      if (data_ok8) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL midrst_no_resp actual=%0d expected=0", pulses); end
    issue8(1'b0, 4'h0, 32'h40, 32'h0);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      if (data_ok8) begin
        got = 1'b1;
        checks++; if (rdata8 !== 32'hCAFEF00D) begin failures++; $display("FAIL midrst_rd actual=%h expected=cafef00d", rdata8); end
      end
      @(negedge clk);
    end
    checks++; if (!got) begin failures++; $display("FAIL midrst_rd_timeout actual=none expected=data_ok"); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_strb_zero();
    test_back_to_back();
    test_full_queue();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
